// File: rtl/time_adjuster.sv
// Time-setting datapath: holds the BCD hours/minutes/seconds being edited,
// applies increment presses (with hold-to-repeat) to the selected field and
// produces a blink mask so the display can flash the field under edit.
module time_adjuster #(
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 2,
   parameter int BLINK_TICKS   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       adjuster_clk,
   input  logic       adjuster_load,
   input  logic [2:0] adjust_mode,
   input  logic       increment,
   input  logic [7:0] timer_hours,
   input  logic [7:0] timer_minutes,
   input  logic [7:0] timer_seconds,
   output logic [7:0] adj_hours,
   output logic [7:0] adj_minutes,
   output logic [7:0] adj_seconds,
   output logic [2:0] blank_mask
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
   localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);
   localparam logic [15:0] BLINK_LAST  = 16'(BLINK_TICKS - 1);

   logic        prev_adjuster_clk_r;
   logic        prev_increment_r;
   logic [2:0]  prev_mode_r;
   logic        pending_r;
   logic        hold_block_r;   // button held through reset; cleared once released
   logic [1:0]  state_r;
   logic [15:0] cnt_r;
   logic [15:0] blink_cnt_r;
   logic        blink_phase_r;  // 1 = field blanked
   logic [7:0]  adj_hours_r;
   logic [7:0]  adj_minutes_r;
   logic [7:0]  adj_seconds_r;

   logic        tick_s;
   logic        press_s;
   logic        mode_valid_s;
   logic        mode_change_s;
   logic [1:0]  fsm_cur_s;
   logic [1:0]  state_next_s;
   logic [15:0] cnt_next_s;
   logic        step_s;
   logic        blink_restart_s;
   logic [15:0] blink_cnt_next_s;
   logic        blink_phase_next_s;
   logic [7:0]  hours_next_s;
   logic [7:0]  minutes_next_s;
   logic [7:0]  seconds_next_s;

   // Advance one BCD field, wrapping at its limit; out-of-range values go to 00.
   function automatic logic [7:0] bcd_step(input logic [7:0] value, input logic [7:0] limit);
      logic [7:0] result;
      if (value >= limit) begin
         result = 8'h00;
      end else if (value[3:0] >= 4'd9) begin
         result = {value[7:4] + 4'd1, 4'd0};
      end else begin
         result = {value[7:4], value[3:0] + 4'd1};
      end
      return result;
   endfunction

   assign tick_s        = adjuster_clk & ~prev_adjuster_clk_r;
   assign press_s       = increment & ~prev_increment_r;
   assign mode_change_s = (adjust_mode != prev_mode_r);

   // Only the three one-hot codes select a field; anything else means idle.
   always_comb begin
      mode_valid_s = 1'b0;
      case (adjust_mode)
         3'b100, 3'b010, 3'b001: mode_valid_s = 1'b1;
         default:                mode_valid_s = 1'b0;
      endcase
   end

   // Hold FSM next state for a tick without load; a mode change restarts from IDLE.
   always_comb begin
      state_next_s = ST_IDLE;
      cnt_next_s   = 16'd0;
      step_s       = 1'b0;
      fsm_cur_s    = mode_change_s ? ST_IDLE : state_r;
      if (!mode_valid_s) begin
         state_next_s = ST_IDLE;
         cnt_next_s   = 16'd0;
      end else begin
         case (fsm_cur_s)
            ST_IDLE: begin
               if ((increment & ~hold_block_r) | pending_r) begin
                  step_s       = 1'b1;
                  state_next_s = ST_DELAY;
               end else begin
                  state_next_s = ST_IDLE;
               end
               cnt_next_s = 16'd0;
            end
            ST_DELAY: begin
               if (!increment) begin
                  state_next_s = ST_IDLE;
                  cnt_next_s   = 16'd0;
               end else if (cnt_r == DELAY_LAST) begin
                  step_s       = 1'b1;
                  state_next_s = ST_REPEAT;
                  cnt_next_s   = 16'd0;
               end else begin
                  state_next_s = ST_DELAY;
                  cnt_next_s   = cnt_r + 16'd1;
               end
            end
            ST_REPEAT: begin
               if (!increment) begin
                  state_next_s = ST_IDLE;
                  cnt_next_s   = 16'd0;
               end else if (cnt_r == PERIOD_LAST) begin
                  step_s       = 1'b1;
                  state_next_s = ST_REPEAT;
                  cnt_next_s   = 16'd0;
               end else begin
                  state_next_s = ST_REPEAT;
                  cnt_next_s   = cnt_r + 16'd1;
               end
            end
            default: begin
               state_next_s = ST_IDLE;
               cnt_next_s   = 16'd0;
            end
         endcase
      end
   end

   // Blink timing; any visible change restarts the visible half-period.
   always_comb begin
      blink_restart_s    = step_s | mode_change_s | ~mode_valid_s;
      blink_cnt_next_s   = 16'd0;
      blink_phase_next_s = 1'b0;
      if (blink_restart_s) begin
         blink_cnt_next_s   = 16'd0;
         blink_phase_next_s = 1'b0;
      end else if (blink_cnt_r == BLINK_LAST) begin
         blink_cnt_next_s   = 16'd0;
         blink_phase_next_s = ~blink_phase_r;
      end else begin
         blink_cnt_next_s   = blink_cnt_r + 16'd1;
         blink_phase_next_s = blink_phase_r;
      end
   end

   // Field update: only the selected field steps, no carry between fields.
   always_comb begin
      hours_next_s   = adj_hours_r;
      minutes_next_s = adj_minutes_r;
      seconds_next_s = adj_seconds_r;
      if (step_s) begin
         case (adjust_mode)
            3'b100:  hours_next_s   = bcd_step(adj_hours_r, 8'h23);
            3'b010:  minutes_next_s = bcd_step(adj_minutes_r, 8'h59);
            3'b001:  seconds_next_s = bcd_step(adj_seconds_r, 8'h59);
            default: hours_next_s   = adj_hours_r;
         endcase
      end else begin
         hours_next_s = adj_hours_r;
      end
   end

   // State registers; everything except edge/press tracking moves only on ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_adjuster_clk_r <= 1'b0;
         prev_increment_r    <= 1'b1;
         prev_mode_r         <= 3'b000;
         pending_r           <= 1'b0;
         hold_block_r        <= 1'b1;
         state_r             <= ST_IDLE;
         cnt_r               <= 16'd0;
         blink_cnt_r         <= 16'd0;
         blink_phase_r       <= 1'b0;
         adj_hours_r         <= 8'h00;
         adj_minutes_r       <= 8'h00;
         adj_seconds_r       <= 8'h00;
      end else begin
         prev_adjuster_clk_r <= adjuster_clk;
         prev_increment_r    <= increment;
         if (!increment) begin
            hold_block_r <= 1'b0;
         end
         if (tick_s) begin
            pending_r <= 1'b0;
         end else if (press_s) begin
            pending_r <= 1'b1;
         end
         if (tick_s) begin
            prev_mode_r <= adjust_mode;
            if (adjuster_load) begin
               adj_hours_r   <= timer_hours;
               adj_minutes_r <= timer_minutes;
               adj_seconds_r <= timer_seconds;
               state_r       <= ST_IDLE;
               cnt_r         <= 16'd0;
               blink_cnt_r   <= 16'd0;
               blink_phase_r <= 1'b0;
            end else begin
               adj_hours_r   <= hours_next_s;
               adj_minutes_r <= minutes_next_s;
               adj_seconds_r <= seconds_next_s;
               state_r       <= state_next_s;
               cnt_r         <= cnt_next_s;
               blink_cnt_r   <= blink_cnt_next_s;
               blink_phase_r <= blink_phase_next_s;
            end
         end
      end
   end

   assign adj_hours   = adj_hours_r;
   assign adj_minutes = adj_minutes_r;
   assign adj_seconds = adj_seconds_r;
   assign blank_mask  = (blink_phase_r & mode_valid_s) ? adjust_mode : 3'b000;

endmodule
